// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: LFSR hole pick, gap/up timing, scoring and game-over handling.
// Define MOLE_MISS_PENALTY_EN to make timeouts and wrong presses cost one point each.
module mole_scheduler #(
    parameter int UP_CYCLES  = 20000,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_hit,
    input  logic [4:0] i_seconds,
    input  logic       i_game_over,
    output logic       o_restart_game,
    output logic [3:0] o_mole,
    output logic [7:0] o_score,
    output logic       o_playing
);

    localparam int MAX_C = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_FULL_LAST = CNT_W'(UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_HALF_LAST = CNT_W'(UP_CYCLES / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] up_cnt_q, up_cnt_d;
    logic [CNT_W-1:0] up_last_q, up_last_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [1:0]       prev_q, prev_d;
    logic [3:0]       mole_q, mole_d;
    logic [7:0]       score_q, score_d;
    logic             restart_q, restart_d;
    logic             go_mask_q, go_mask_d;
    logic             playing_q, playing_d;

    logic [1:0] hole_raw, hole_sel;
    logic       hit_match, timeout, go_ok;

    assign hole_raw  = lfsr_q[1:0];
    assign hole_sel  = (hole_raw == prev_q) ? hole_raw + 2'd1 : hole_raw;
    assign hit_match = |(i_hit & mole_q);
    assign timeout   = (up_cnt_q == up_last_q);
    // The countdown timer needs two cycles to clear after a restart pulse.
    assign go_ok     = i_game_over && !restart_q && !go_mask_q;

`ifdef MOLE_MISS_PENALTY_EN
    logic       wrong_press;
    logic [1:0] penalty;
    assign wrong_press = (i_hit != 4'd0) && !hit_match;
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        up_cnt_d  = up_cnt_q;
        up_last_d = up_last_q;
        prev_d    = prev_q;
        mole_d    = mole_q;
        score_d   = score_q;
        restart_d = 1'b0;
        go_mask_d = restart_q;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef MOLE_MISS_PENALTY_EN
        penalty   = 2'd0;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (i_start) begin
                    state_d   = S_GAP;
                    restart_d = 1'b1;
                    score_d   = 8'd0;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (go_ok) begin
                    state_d = S_OVER;
                    mole_d  = 4'd0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_UP;
                    mole_d    = 4'b0001 << hole_sel;
                    prev_d    = hole_sel;
                    up_cnt_d  = '0;
                    up_last_d = (i_seconds >= 5'd10) ? UP_FULL_LAST : UP_HALF_LAST;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_ONE;
                end
            end
            S_UP: begin
                if (go_ok) begin
                    state_d = S_OVER;
                    mole_d  = 4'd0;
                end else if (hit_match) begin
                    score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    mole_d    = 4'd0;
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    if (timeout) begin
                        mole_d    = 4'd0;
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        up_cnt_d = up_cnt_q + CNT_ONE;
                    end
`ifdef MOLE_MISS_PENALTY_EN
                    penalty = {1'b0, timeout} + {1'b0, wrong_press};
                    score_d = (score_q > {6'd0, penalty}) ? score_q - {6'd0, penalty} : 8'd0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        playing_d = (state_d == S_GAP) || (state_d == S_UP);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            up_cnt_q  <= '0;
            up_last_q <= '0;
            lfsr_q    <= 8'hA5;
            prev_q    <= 2'd0;
            mole_q    <= 4'd0;
            score_q   <= 8'd0;
            restart_q <= 1'b0;
            go_mask_q <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            up_cnt_q  <= up_cnt_d;
            up_last_q <= up_last_d;
            lfsr_q    <= lfsr_d;
            prev_q    <= prev_d;
            mole_q    <= mole_d;
            score_q   <= score_d;
            restart_q <= restart_d;
            go_mask_q <= go_mask_d;
            playing_q <= playing_d;
        end
    end

    assign o_restart_game = restart_q;
    assign o_mole         = mole_q;
    assign o_score        = score_q;
    assign o_playing      = playing_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: a behavioural model feeds a per-cycle scoreboard,
// directed scenarios check timing, scoring, game-over and reset behaviour.
module tb_mole_scheduler;

    localparam int UP_C  = 8;
    localparam int GAP_C = 4;
`ifdef MOLE_MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hit = 4'd0;
    logic [4:0] seconds = 5'd29;
    logic       game_over = 1'b0;
    logic       restart_game;
    logic [3:0] mole;
    logic [7:0] score;
    logic       playing;

    mole_scheduler #(.UP_CYCLES(UP_C), .GAP_CYCLES(GAP_C)) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_hit(hit), .i_seconds(seconds),
        .i_game_over(game_over), .o_restart_game(restart_game), .o_mole(mole),
        .o_score(score), .o_playing(playing)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic       pl;
        logic [3:0] mo;
        logic [7:0] sc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state: 0 idle, 1 gap, 2 up, 3 over; m_hole = -1 when no mole
    int       m_st, m_gap, m_up, m_len, m_prev, m_hole, m_score;
    bit       m_restart, m_mask;
    bit [7:0] m_lfsr;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(output exp_t e);
        int       n_st, n_gap, n_up, n_len, n_prev, n_hole, n_score, h;
        bit       n_restart, n_mask, go, matched;
        bit [7:0] n_lfsr;
        n_st = m_st; n_gap = m_gap; n_up = m_up; n_len = m_len;
        n_prev = m_prev; n_hole = m_hole; n_score = m_score;
        n_restart = 1'b0;
        n_mask = m_restart;
        n_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        go = game_over && !m_restart && !m_mask;
        if (rst) begin
            n_st = 0; n_gap = 0; n_up = 0; n_len = 0; n_prev = 0; n_hole = -1;
            n_score = 0; n_mask = 1'b0; n_lfsr = 8'hA5;
        end else if (m_st == 0 || m_st == 3) begin
            if (start) begin
                n_st = 1; n_restart = 1'b1; n_score = 0; n_gap = 0;
            end
        end else if (m_st == 1) begin
            if (go) begin
                n_st = 3; n_hole = -1;
            end else if (m_gap == GAP_C - 1) begin
                h = int'(m_lfsr[1:0]);
                if (h == m_prev) h = (h + 1) % 4;
                n_st = 2; n_hole = h; n_prev = h; n_up = 0;
                n_len = (seconds >= 10) ? UP_C : UP_C / 2;
            end else begin
                n_gap = m_gap + 1;
            end
        end else begin
            matched = hit[m_hole];
            if (go) begin
                n_st = 3; n_hole = -1;
            end else if (matched) begin
                n_score = (m_score < 255) ? m_score + 1 : 255;
                n_hole = -1; n_st = 1; n_gap = 0;
            end else begin
                if (m_up == m_len - 1) begin
                    n_hole = -1; n_st = 1; n_gap = 0;
                    if (PEN != 0) n_score = n_score - 1;
                end else begin
                    n_up = m_up + 1;
                end
                if (PEN != 0 && hit != 4'd0) n_score = n_score - 1;
                if (n_score < 0) n_score = 0;
            end
        end
        m_st = n_st; m_gap = n_gap; m_up = n_up; m_len = n_len; m_prev = n_prev;
        m_hole = n_hole; m_score = n_score; m_restart = n_restart; m_mask = n_mask;
        m_lfsr = n_lfsr;
        e.rs = n_restart;
        e.pl = (n_st == 1 || n_st == 2);
        e.mo = (n_hole < 0) ? 4'd0 : (4'b0001 << n_hole);
        e.sc = n_score[7:0];
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("sb", int'({restart_game, playing, mole, score}), int'(e));
    endtask

    task automatic wait_mole(output int n);
        n = 0;
        while (mole == 4'd0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_val("wait_mole", int'(mole != 4'd0), 1);
    endtask

    task automatic hit_mole();
        hit = mole;
        tick();
        hit = 4'd0;
    endtask

    task automatic count_up(input bit wrong_first, output int n);
        n = 0;
        while (mole != 4'd0 && n < 100) begin
            if (wrong_first && n == 0) hit = ~mole;
            tick();
            hit = 4'd0;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int       n;
        logic [3:0] last;
        m_st = 0; m_gap = 0; m_up = 0; m_len = 0; m_prev = 0; m_hole = -1;
        m_score = 0; m_restart = 0; m_mask = 0; m_lfsr = 8'hA5;

        // reset
        rst = 1'b1;
        tick(); tick();
        check_val("reset_outs", int'({restart_game, playing, mole, score}), 0);
        rst = 1'b0;
        tick();
        check_val("idle_playing", int'(playing), 0);

        // start: one-cycle restart pulse, mole 4 clocks after GAP entry
        seconds = 5'd29;
        start = 1'b1; tick(); start = 1'b0;
        check_val("restart_pulse", int'(restart_game), 1);
        check_val("playing_gap", int'(playing), 1);
        check_val("score_clear", int'(score), 0);
        wait_mole(n);
        check_val("gap_len", n, GAP_C);
        check_val("restart_one_cycle", int'(restart_game), 0);
        check_val("mole_onehot", int'($countones(mole)), 1);

        // hit in the third UP cycle
        tick(); tick();
        last = mole;
        hit_mole();
        check_val("hit_score", int'(score), 1);
        check_val("hit_mole_clear", int'(mole), 0);
        wait_mole(n);
        check_val("gap_after_hit", n, GAP_C);
        check_val("new_hole_diff", int'(mole != last), 1);

        // multi-bit press still scores, then one more hit -> 3
        hit = 4'hF; tick(); hit = 4'd0;
        check_val("multi_bit_hit", int'(score), 2);
        wait_mole(n);
        hit_mole();
        check_val("score_three", int'(score), 3);

        // misses: long window at 29 s, half window at 5 s with a wrong press
        wait_mole(n);
        count_up(1'b0, n);
        check_val("up_len_29", n, UP_C);
        check_val("miss_29_score", int'(score), 3 - PEN);
        seconds = 5'd5;
        wait_mole(n);
        count_up(1'b1, n);
        check_val("up_len_5", n, UP_C / 2);
        check_val("miss_5_score", int'(score), (PEN != 0) ? 0 : 3);

        // hit and game-over together: game-over wins
        seconds = 5'd29;
        wait_mole(n);
        hit = mole; game_over = 1'b1; tick(); hit = 4'd0; game_over = 1'b0;
        check_val("go_playing", int'(playing), 0);
        check_val("go_mole", int'(mole), 0);
        check_val("go_score", int'(score), (PEN != 0) ? 0 : 3);
        hit = 4'hF; tick(); hit = 4'd0;
        check_val("over_hit_ignored", int'(score), (PEN != 0) ? 0 : 3);

        // restart from OVER, game-over masked for two cycles
        start = 1'b1; game_over = 1'b1; tick(); start = 1'b0;
        check_val("restart2_pulse", int'(restart_game), 1);
        check_val("restart2_score", int'(score), 0);
        tick();
        check_val("go_mask_0", int'(playing), 1);
        tick();
        check_val("go_mask_1", int'(playing), 1);
        tick();
        check_val("go_after_mask", int'(playing), 0);
        game_over = 1'b0;

        // start ignored during GAP
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check_val("gap_start_ignored", int'(restart_game), 0);
        wait_mole(n);
        check_val("gap_len_start_ign", n, GAP_C - 2);
        hit_mole();

        // saturation at 255
        for (int i = 1; i < 255; i++) begin
            wait_mole(n);
            hit_mole();
        end
        check_val("score_255", int'(score), 255);
        wait_mole(n);
        hit_mole();
        check_val("score_sat", int'(score), 255);

        // reset during UP overrides everything
        wait_mole(n);
        rst = 1'b1; hit = mole; start = 1'b1; tick();
        rst = 1'b0; hit = 4'd0; start = 1'b0;
        check_val("rst_up_outs", int'({restart_game, playing, mole, score}), 0);
        game_over = 1'b1; hit = 4'hF; tick(); game_over = 1'b0; hit = 4'd0;
        check_val("rst_idle", int'({restart_game, playing, mole, score}), 0);
        start = 1'b1; tick(); start = 1'b0;
        check_val("rst_restart", int'(restart_game), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 The block SHALL have parameter UP_CYCLES, default 20000, giving the clocks a mole stays up while i_seconds >= 10.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 5000, giving the clocks between moles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_start, input, 1 bit: a one-cycle start/restart request.
REQ-006 The block SHALL have port i_hit, input, 4 bits: one-cycle whack pulses, one bit per hole.
REQ-007 The block SHALL have port i_seconds, input, 5 bits: seconds remaining, from the countdown timer.
REQ-008 The block SHALL have port i_game_over, input, 1 bit: game-over flag, from the countdown timer.
REQ-009 The block SHALL have port o_restart_game, output, 1 bit: a one-cycle pulse to the countdown timer restart input.
REQ-010 The block SHALL have port o_mole, output, 4 bits: one-hot active mole, or all zero when no mole is up.
REQ-011 The block SHALL have port o_score, output, 8 bits: score, saturating.
REQ-012 The block SHALL have port o_playing, output, 1 bit: high in states GAP and UP.

Function
REQ-013 The state machine SHALL have states IDLE, GAP, UP and OVER, all registered.
REQ-014 On i_start in IDLE or OVER, next cycle: state=GAP, o_restart_game=1 for exactly one cycle, o_score=0, gap counter=0.
REQ-015 i_start SHALL be ignored in GAP and UP.
REQ-016 In GAP the counter SHALL increment each clock; at count GAP_CYCLES-1: state=UP, o_mole=one-hot(selected hole), up counter=0.
REQ-017 The up limit SHALL be UP_CYCLES when i_seconds >= 10 and UP_CYCLES/2 (integer) when i_seconds < 10, sampled on GAP->UP entry.
REQ-018 Hole select SHALL be h=lfsr[1:0]; if h equals the previous hole then (h+1) mod 4; the previous hole SHALL be 0 after reset.
REQ-019 The LFSR SHALL be 8 bits, taps x^8+x^6+x^5+x^4+1, seeded 8'hA5 by reset, advancing every clock in all states, never all-zero.
REQ-020 In UP, i_hit bit matching o_mole: the score SHALL increment (saturating at 255) next cycle, o_mole=0, state=GAP, gap counter=0.
REQ-021 In UP, when the up counter reaches limit-1 with no matching hit, it SHALL be a miss: o_mole=0, state=GAP.
REQ-022 A matching hit in the timeout cycle SHALL count as a hit.
REQ-023 A matching bit SHALL count as a hit even when other i_hit bits are set in the same cycle.
REQ-024 i_hit SHALL be ignored outside UP.
REQ-025 i_game_over=1 in GAP or UP SHALL give, next cycle: state=OVER, o_mole=0, o_score held.
REQ-026 Game-over SHALL take priority over a simultaneous hit, which is not scored.
REQ-027 i_game_over SHALL be ignored in the o_restart_game cycle and the cycle after (timer clear latency).
REQ-028 In OVER, o_score SHALL hold until the next accepted i_start.

Reset
REQ-029 On i_rst=1 at a clock edge: state=IDLE, o_mole=0, o_score=0, o_restart_game=0, o_playing=0, counters=0, LFSR=8'hA5, previous hole=0.
REQ-030 Reset SHALL override every other input in the same cycle, including mid-game, and a pending restart pulse SHALL be dropped.

Configuration
REQ-031 The block SHALL support macro MOLE_MISS_PENALTY_EN.
REQ-032 With MOLE_MISS_PENALTY_EN defined, each UP timeout miss and each UP cycle with an i_hit bit set but no matching bit SHALL decrement o_score, saturating at 0.
REQ-033 A wrong press SHALL NOT end the mole.
REQ-034 With MOLE_MISS_PENALTY_EN undefined, misses and wrong presses SHALL NOT change o_score and the penalty logic SHALL be absent.

Verification (UP_CYCLES=8, GAP_CYCLES=4)
REQ-035 Reset, then i_start, then i_seconds=29 -> o_restart_game pulse of one cycle, o_playing=1, o_mole!=0 exactly 4 clocks after GAP entry.
REQ-036 Matching i_hit in the third UP cycle -> o_score 0->1, o_mole=0 next cycle; the next mole selects a different hole than the last.
REQ-037 No hit with i_seconds=29 -> mole up 8 clocks; with i_seconds=5 -> mole up 4 clocks; o_score unchanged (penalty off) or 3->2 (penalty on).
REQ-038 Matching hit and i_game_over in the same cycle -> state OVER, o_score unchanged, o_mole=0; a later i_start -> o_score=0 and a new restart pulse.
REQ-039 Score forced to 255 followed by a hit -> stays 255; i_rst asserted during UP -> all outputs zero next cycle, state IDLE.
